// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: operand-forwarding and load-use hazard unit beside DE.
// Keeps a shift history of in-flight destination registers (entry k is the
// instruction in stage k). For each source port it selects the youngest
// producer to forward from, or requests a stall if that producer's result
// is not ready yet.
// Optional build macro FWD_SCOREBOARD_STALL_CNT_EN adds the saturating
// stall_cnt / fwd_cnt event counters.
module fwd_scoreboard #(
    parameter int NPORTS     = 2,
    parameter int NSTAGES    = 2,
    parameter int LOAD_STAGE = 2,
    parameter int SELW       = $clog2(NSTAGES + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     de_valid,
    input  logic [NPORTS*5-1:0]      de_rs,
    input  logic [NPORTS-1:0]        de_rs_used,
    input  logic                     de_regWrite,
    input  logic [4:0]               de_rd,
    input  logic                     de_isLoad,
    input  logic                     hold,
    input  logic                     flush,
`ifdef FWD_SCOREBOARD_STALL_CNT_EN
    output logic [31:0]              stall_cnt,
    output logic [31:0]              fwd_cnt,
`endif
    output logic [NPORTS*SELW-1:0]   fwd_sel,
    output logic                     stall_req
);

    // Reject configurations the history cannot represent.
    if (LOAD_STAGE < 1 || LOAD_STAGE > NSTAGES || NPORTS < 1) begin : g_param_check
        $fatal(1, "fwd_scoreboard: illegal parameters (LOAD_STAGE must be 1..NSTAGES, NPORTS >= 1)");
    end

    // History: valid bit, destination register, first stage the result is forwardable.
    logic [NSTAGES:1] ent_v;
    logic [4:0]       ent_rd  [1:NSTAGES];
    logic [SELW-1:0]  ent_rdy [1:NSTAGES];

    logic [4:0]       cur_rs;
    logic             cur_hit;
    logic             cur_wait;
    logic [SELW-1:0]  cur_sel;
    logic             any_wait;
    logic             push;

    // Per-port youngest-match search; the first hit (smallest k) is taken.
    always_comb begin
        fwd_sel  = '0;
        any_wait = 1'b0;
        cur_rs   = '0;
        cur_hit  = 1'b0;
        cur_wait = 1'b0;
        cur_sel  = '0;
        for (int unsigned p = 0; p < NPORTS; p++) begin
            cur_rs   = de_rs[5*p +: 5];
            cur_hit  = 1'b0;
            cur_wait = 1'b0;
            cur_sel  = '0;
            for (int unsigned k = 1; k <= NSTAGES; k++) begin
                if (!cur_hit && de_rs_used[p] && (cur_rs != 5'd0) &&
                    ent_v[k] && (ent_rd[k] == cur_rs)) begin
                    cur_hit = 1'b1;
                    if (SELW'(k) >= ent_rdy[k]) begin
                        cur_sel = SELW'(k);
                    end else begin
                        cur_wait = 1'b1;
                    end
                end
            end
            fwd_sel[SELW*p +: SELW] = rst_n ? cur_sel : '0;
            any_wait = any_wait | cur_wait;
        end
        stall_req = rst_n & de_valid & ~flush & any_wait;
    end

    // A DE instruction is recorded only if it will really advance into EX.
    always_comb begin
        push = de_valid & de_regWrite & (de_rd != 5'd0) & ~stall_req & ~flush;
    end

    // Shift the history one stage per unfrozen cycle; entry 1 takes DE or a bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ent_v <= '0;
        end else if (!hold) begin
            for (int unsigned k = 2; k <= NSTAGES; k++) begin
                ent_v[k]   <= ent_v[k-1];
                ent_rd[k]  <= ent_rd[k-1];
                ent_rdy[k] <= ent_rdy[k-1];
            end
            ent_v[1]   <= push;
            ent_rd[1]  <= de_rd;
            ent_rdy[1] <= de_isLoad ? SELW'(LOAD_STAGE) : SELW'(1);
        end
    end

`ifdef FWD_SCOREBOARD_STALL_CNT_EN
    // Saturating counts of stalled cycles and of cycles that forwarded anything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            fwd_cnt   <= '0;
        end else if (!hold) begin
            if (stall_req && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (!stall_req && (fwd_sel != '0) && (fwd_cnt != '1)) begin
                fwd_cnt <= fwd_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// tb_fwd_scoreboard: scoreboard bench for fwd_scoreboard (default parameters).
// The driver pushes expected outputs into a queue; a negedge monitor pops
// and compares against the DUT outputs.
module tb_fwd_scoreboard;

    localparam int NPORTS = 2;
    localparam int NSTAGES = 2;
    localparam int LOAD_STAGE = 2;
    localparam int SELW = 2;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   de_valid;
    logic [NPORTS*5-1:0]    de_rs;
    logic [NPORTS-1:0]      de_rs_used;
    logic                   de_regWrite;
    logic [4:0]             de_rd;
    logic                   de_isLoad;
    logic                   hold;
    logic                   flush;
    logic [NPORTS*SELW-1:0] fwd_sel;
    logic                   stall_req;
`ifdef FWD_SCOREBOARD_STALL_CNT_EN
    logic [31:0]            stall_cnt;
    logic [31:0]            fwd_cnt;
    int unsigned            m_stall_cnt;
    int unsigned            m_fwd_cnt;
`endif

    fwd_scoreboard #(
        .NPORTS(NPORTS),
        .NSTAGES(NSTAGES),
        .LOAD_STAGE(LOAD_STAGE),
        .SELW(SELW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .de_valid(de_valid),
        .de_rs(de_rs),
        .de_rs_used(de_rs_used),
        .de_regWrite(de_regWrite),
        .de_rd(de_rd),
        .de_isLoad(de_isLoad),
        .hold(hold),
        .flush(flush),
`ifdef FWD_SCOREBOARD_STALL_CNT_EN
        .stall_cnt(stall_cnt),
        .fwd_cnt(fwd_cnt),
`endif
        .fwd_sel(fwd_sel),
        .stall_req(stall_req)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NPORTS*SELW-1:0] sel;
        logic                   stall;
        string                  name;
    } exp_t;

    typedef struct {
        bit       v;
        bit [4:0] rd;
        int       rdy;
    } hent_t;

    exp_t  exp_q[$];
    hent_t hist[$];   // hist[0] is the instruction in stage 1
    int    tests = 0;
    int    failed = 0;

    // Monitor: compare DUT outputs with the oldest pending expectation.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (fwd_sel !== e.sel || stall_req !== e.stall) begin
                failed++;
                $display("FAIL %s: fwd_sel=%h stall_req=%b, expected fwd_sel=%h stall_req=%b",
                         e.name, fwd_sel, stall_req, e.sel, e.stall);
            end
        end
    end

    // Reference: search the in-flight list youngest-first for each source.
    task automatic model_eval(input bit rst, input bit valid, input bit [4:0] rs0,
                              input bit [4:0] rs1, input bit [1:0] used, input bit fl,
                              output logic [NPORTS*SELW-1:0] sel, output logic stall);
        bit [4:0] rs [2];
        bit       waiting;
        rs[0] = rs0;
        rs[1] = rs1;
        sel = '0;
        waiting = 0;
        for (int p = 0; p < NPORTS; p++) begin
            for (int i = 0; i < hist.size(); i++) begin
                if (used[p] && rs[p] != 0 && hist[i].v && hist[i].rd == rs[p]) begin
                    if (i + 1 >= hist[i].rdy) sel[SELW*p +: SELW] = SELW'(i + 1);
                    else waiting = 1;
                    break;
                end
            end
        end
        stall = valid && !fl && waiting;
        if (!rst) begin
            sel = '0;
            stall = 1'b0;
        end
    endtask

    task automatic step(input bit rst, input bit valid, input bit [4:0] rs0, input bit [4:0] rs1,
                        input bit [1:0] used, input bit regw, input bit [4:0] rd, input bit ld,
                        input bit hd, input bit fl, input bit chk_const,
                        input logic [3:0] csel, input logic cstall, input string name);
        exp_t  e;
        hent_t n;
        logic [NPORTS*SELW-1:0] msel;
        logic  mstall;
        rst_n = rst; de_valid = valid; de_rs = {rs1, rs0}; de_rs_used = used;
        de_regWrite = regw; de_rd = rd; de_isLoad = ld; hold = hd; flush = fl;
        model_eval(rst, valid, rs0, rs1, used, fl, msel, mstall);
        e.sel   = chk_const ? csel : msel;
        e.stall = chk_const ? cstall : mstall;
        e.name  = name;
        exp_q.push_back(e);
        @(posedge clk);
        if (!rst) begin
            foreach (hist[i]) hist[i].v = 0;
        end else if (!hd) begin
            n.v   = valid && regw && rd != 0 && !mstall && !fl;
            n.rd  = rd;
            n.rdy = ld ? LOAD_STAGE : 1;
            hist.push_front(n);
            void'(hist.pop_back());
        end
`ifdef FWD_SCOREBOARD_STALL_CNT_EN
        if (!rst) begin
            m_stall_cnt = 0;
            m_fwd_cnt = 0;
        end else if (!hd) begin
            if (mstall) m_stall_cnt++;
            else if (msel != 0) m_fwd_cnt++;
        end
`endif
        #1;
    endtask

    initial begin
        hent_t b;
        b.v = 0; b.rd = 0; b.rdy = 1;
        repeat (NSTAGES) hist.push_back(b);
`ifdef FWD_SCOREBOARD_STALL_CNT_EN
        m_stall_cnt = 0;
        m_fwd_cnt = 0;
`endif
        rst_n = 0; de_valid = 0; de_rs = '0; de_rs_used = '0; de_regWrite = 0;
        de_rd = 0; de_isLoad = 0; hold = 0; flush = 0;
        @(posedge clk); #1;

        //   rst vld rs0 rs1 used regw rd ld hd fl chk sel  stall
        step(0, 1, 5, 5, 2'b11, 1, 5, 0, 0, 0, 1, 4'h0, 0, "reset_outputs");
        // ALU chain
        step(1, 1, 0, 0, 2'b00, 1, 5, 0, 0, 0, 1, 4'h0, 0, "alu_issue");
        step(1, 1, 5, 0, 2'b01, 0, 0, 0, 0, 0, 1, 4'h1, 0, "alu_fwd1");
        step(1, 1, 5, 0, 2'b01, 0, 0, 0, 0, 0, 1, 4'h2, 0, "alu_fwd2");
        step(1, 1, 5, 0, 2'b01, 0, 0, 0, 0, 0, 1, 4'h0, 0, "alu_regfile");
        // Load-use
        step(1, 1, 0, 0, 2'b00, 1, 7, 1, 0, 0, 1, 4'h0, 0, "ld_issue");
        step(1, 1, 0, 7, 2'b10, 0, 0, 0, 0, 0, 1, 4'h0, 1, "ld_use_stall");
        step(1, 1, 0, 7, 2'b10, 0, 0, 0, 0, 0, 1, 4'h8, 0, "ld_use_fwd2");
        // Priority and x0
        step(1, 1, 0, 0, 2'b00, 1, 3, 0, 0, 0, 1, 4'h0, 0, "x3_first");
        step(1, 1, 0, 0, 2'b00, 1, 3, 0, 0, 0, 1, 4'h0, 0, "x3_second");
        step(1, 1, 3, 3, 2'b11, 0, 0, 0, 0, 0, 1, 4'h5, 0, "dup_youngest");
        step(1, 1, 0, 0, 2'b00, 1, 0, 0, 0, 0, 1, 4'h0, 0, "x0_write");
        step(1, 1, 0, 0, 2'b11, 0, 0, 0, 0, 0, 1, 4'h0, 0, "x0_read");
        step(1, 1, 0, 0, 2'b00, 1, 9, 0, 0, 0, 1, 4'h0, 0, "x9_write");
        step(1, 1, 9, 9, 2'b00, 0, 0, 0, 0, 0, 1, 4'h0, 0, "unused_port");
        // Hold
        step(1, 1, 0, 0, 2'b00, 1, 7, 1, 0, 0, 1, 4'h0, 0, "hold_ld");
        step(1, 1, 7, 0, 2'b01, 0, 0, 0, 1, 0, 1, 4'h0, 1, "hold_stall_a");
        step(1, 1, 7, 0, 2'b01, 0, 0, 0, 1, 0, 1, 4'h0, 1, "hold_stall_b");
        step(1, 1, 7, 0, 2'b01, 0, 0, 0, 1, 0, 1, 4'h0, 1, "hold_stall_c");
        step(1, 1, 7, 0, 2'b01, 0, 0, 0, 0, 0, 1, 4'h0, 1, "hold_release");
        step(1, 1, 7, 0, 2'b01, 0, 0, 0, 0, 0, 1, 4'h2, 0, "hold_fwd2");
        // Flush
        step(1, 1, 0, 0, 2'b00, 1, 7, 1, 0, 0, 1, 4'h0, 0, "flush_ld");
        step(1, 1, 7, 0, 2'b01, 0, 0, 0, 0, 1, 1, 4'h0, 0, "flush_wins");
        step(1, 1, 7, 0, 2'b01, 0, 0, 0, 0, 0, 1, 4'h2, 0, "flush_fwd2");
        // Reset with two valid entries
        step(1, 1, 0, 0, 2'b00, 1, 4, 0, 0, 0, 1, 4'h0, 0, "x4_write");
        step(1, 1, 0, 0, 2'b00, 1, 6, 0, 0, 0, 1, 4'h0, 0, "x6_write");
        step(0, 1, 6, 4, 2'b11, 0, 0, 0, 0, 0, 1, 4'h0, 0, "reset_forced");
        step(1, 1, 6, 4, 2'b11, 0, 0, 0, 0, 0, 1, 4'h0, 0, "post_reset");

        // Randomized traffic over a small register window to provoke hazards.
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 49) != 0,
                 $urandom_range(0, 9) != 0,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 2'($urandom_range(0, 3)),
                 $urandom_range(0, 9) < 7,
                 5'($urandom_range(0, 7)),
                 $urandom_range(0, 9) < 4,
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 9) == 0,
                 0, 4'h0, 0, "random");
        end

        repeat (2) @(posedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            failed++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
`ifdef FWD_SCOREBOARD_STALL_CNT_EN
        tests++;
        if (stall_cnt !== m_stall_cnt) begin
            failed++;
            $display("FAIL stall_cnt: got %0d, expected %0d", stall_cnt, m_stall_cnt);
        end
        tests++;
        if (fwd_cnt !== m_fwd_cnt) begin
            failed++;
            $display("FAIL fwd_cnt: got %0d, expected %0d", fwd_cnt, m_fwd_cnt);
        end
`endif
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/fwd_scoreboard.md
Name: fwd_scoreboard

Overview:
- Parametrised operand-forwarding and hazard unit for the pipelined core. Generalises the fixed two-source EM/MW forwarding mux select to NSTAGES forwarding sources and NPORTS source operands.
- Keeps its own registered history of in-flight destination registers, replacing decode of em_*/mw_* buses.
- Issues a load-use stall request when the youngest producer's result is not yet forwardable.
- Sits beside the DE stage and drives the EX operand muxes and the IF/DE stall/bubble logic.

Parameters:
- NPORTS, 2, number of source operands checked per instruction.
- NSTAGES, 2, history depth; stage 1 = EM, stage 2 = MW, ... stage NSTAGES = last forwardable stage.
- LOAD_STAGE, 2, first stage at which a load result can be forwarded; legal range 1..NSTAGES.
- SELW, $clog2(NSTAGES+1), width of each forward select field.

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous reset, active-low
- de_valid  in  1  DE holds a valid instruction
- de_rs  in  NPORTS*5  source register indices; port p at bits [5p+4:5p]
- de_rs_used  in  NPORTS  port p actually reads its register
- de_regWrite  in  1  DE instruction writes rd
- de_rd  in  5  DE destination register
- de_isLoad  in  1  DE instruction is a load
- hold  in  1  global pipeline freeze (e.g. memory wait)
- flush  in  1  kill the DE instruction (branch redirect)
- fwd_sel  out  NPORTS*SELW  per port: 0 = register file, k = forward from stage k
- stall_req  out  1  freeze IF/DE and inject a bubble into EX

Behaviour:
- State: NSTAGES entries, each {v, rd[4:0], rdy_stage}. Entry k is the instruction now in stage k.
- Reset: synchronous. On a clk edge with rst_n=0, every v clears. While rst_n=0, fwd_sel=0 and stall_req=0 are forced regardless of inputs.
- Match for port p: de_rs_used[p] & de_rs[p]!=0 & entry k valid & entry k rd==de_rs[p]. The youngest match (smallest k) wins.
- fwd_sel[p]:
  - No match: 0.
  - Youngest match at stage k with k >= rdy_stage: k.
  - Youngest match not ready: fwd_sel[p] = 0 and stall_req asserts.
- stall_req = de_valid & !flush & (any port with a not-ready youngest match).
- Outputs are combinational from registered state and DE inputs. Zero added latency; no registered outputs.
- Update on the clk edge when rst_n=1:
  - hold=1: history unchanged. hold has priority over everything except reset.
  - hold=0: entry k takes entry k-1 for k=2..NSTAGES; entry NSTAGES is discarded.
  - Entry 1 loads {1, de_rd, de_isLoad ? LOAD_STAGE : 1} only when de_valid & de_regWrite & de_rd!=0 & !stall_req & !flush. Otherwise entry 1 becomes a bubble (v=0).
- x0 is never recorded and never matched.
- Stall and flush in the same cycle: flush wins, stall_req=0, a bubble is pushed.
- Duplicate rd in several entries is legal; priority resolves it.
- An entry leaving stage NSTAGES is assumed visible through the register file in the next cycle.
- Elaboration check: LOAD_STAGE outside 1..NSTAGES or NPORTS<1 is a fatal error.

Optional Feature:
- Macro FWD_SCOREBOARD_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt, 32 bits, the number of edges where rst_n=1 & hold=0 & stall_req=1.
  - Cleared by reset; saturates at 32'hFFFF_FFFF.
  - Adds output fwd_cnt, 32 bits, incremented once per edge (rst_n=1, hold=0, stall_req=0) in which any port has non-zero fwd_sel. Same reset and saturation rules.
- Undefined: neither port exists and no counter logic is generated.

Test Plan:
(Defaults: NPORTS=2, NSTAGES=2, LOAD_STAGE=2.)
- ALU chain:
  - Cycle 0: issue add x5.
  - Cycle 1: issue rs1=5 -> fwd_sel[0]=1, stall_req=0.
  - Cycle 2: rs1=5 -> sel 2.
  - Cycle 3: rs1=5 -> sel 0.
- Load-use:
  - Load x7, then rs2=7 -> stall_req=1 for exactly one cycle, bubble recorded.
  - Next cycle fwd_sel[1]=2, stall_req=0.
- Priority and x0:
  - Writes to x3 in two consecutive cycles, then rs1=rs2=3 -> both sels 1.
  - Write x0, then rs1=0 -> sel 0, stall_req 0.
  - rs used bit low with a matching rd -> sel 0.
- Hold:
  - Load x7, hold=1 for 3 cycles with rs1=7 -> stall_req stays 1 and history is unchanged.
  - Drop hold -> one more stall cycle, then sel 2.
- Flush and reset:
  - Flush on load-use cycle -> stall_req=0, bubble pushed; next cycle rs1=7 -> sel 2.
  - With 2 valid entries, rst_n=0 for one edge -> outputs 0 during reset.
  - After release, rs1 matching old rds -> sel 0.
- Counter (macro defined):
  - Three load-use stalls (one under hold=1) -> stall_cnt=2.
  - Reset -> stall_cnt=0; force stall_cnt=32'hFFFF_FFFF, then another stall -> stays 32'hFFFF_FFFF.
